reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//   MIPS general-purpose register file, 32 x 32-bit. Consumes reg_datain from the
//   write-back mux and provides the operands for decode/ALU.
//   Two architectural read ports, one write port, one debug read port for board
//   display, and a counter of committed register writes.
// PARAMETERS
//   DATA_W   32  register width
//   ADDR_W   5   register index width (2**ADDR_W registers)
//   CNT_W    32  width of the write-commit counter
// PORTS
//   clk         in   1       rising-edge clock
//   rst_n       in   1       asynchronous reset, active-low
//   RegWrite    in   1       write enable from control
//   waddr       in   ADDR_W  destination register (rt/rd mux output)
//   reg_datain  in   DATA_W  write data from write-back mux
//   raddr1      in   ADDR_W  read port 1 index (rs)
//   rdata1      out  DATA_W  read port 1 data
//   raddr2      in   ADDR_W  read port 2 index (rt)
//   rdata2      out  DATA_W  read port 2 data
//   dbg_addr    in   ADDR_W  debug read index (switches)
//   dbg_data    out  DATA_W  debug read data (display)
//   wr_count    out  CNT_W   number of committed writes since reset
// BEHAVIOUR
//   - Reset (rst_n=0, asynchronous, any time): all 32 registers and wr_count
//     clear to 0 immediately; read outputs follow, i.e. 0. A write requested in
//     the cycle reset asserts is discarded.
//   - Write: on posedge clk, if RegWrite=1 and waddr!=0, reg[waddr] <= reg_datain
//     and wr_count <= wr_count+1. Latency 1 cycle: new value visible on read
//     ports after the edge.
//   - waddr==0 with RegWrite=1: no storage change, wr_count NOT incremented.
//   - $zero: reg[0] reads 0 on every port, always; never written.
//   - Reads: combinational, asynchronous, from stored array (no clock).
//   - raddr1==raddr2 (or equal to dbg_addr): each port returns the same value.
//   - Read of waddr during a write cycle: returns the OLD value unless
//     REGFILE_BYPASS_EN is defined (see CONFIGURATION).
//   - wr_count wraps from 2**CNT_W-1 to 0; no saturation, no flag.
//   - RegWrite is level-sampled at the edge only; X/glitches between edges ignored.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined: rdata1/rdata2 return reg_datain combinationally
//     when RegWrite=1, waddr!=0 and raddr==waddr (write-before-read in same cycle);
//     dbg_data is never bypassed.
//   REGFILE_BYPASS_EN undefined: read ports always return stored array contents.
// STRUCTURE
//   - Shared package/header: DATA_W, ADDR_W defaults, REG_ZERO = 5'd0,
//     NUM_REGS = 32; reused by decode, forwarding and write-back logic.
//   - One sub-module: reg_read_port (zero-index check + optional bypass mux),
//     instantiated for rdata1, rdata2 (bypass enabled) and dbg_data (bypass off).
//   - Storage and wr_count live in reg_file proper, single always block with
//     asynchronous reset.
// TESTING
//   1. Hold rst_n=0, then release -> rdata1/rdata2/dbg_data=0 for all indices, wr_count=0.
//   2. RegWrite=1, waddr=8, reg_datain=32'hDEADBEEF, one edge; raddr1=8 ->
//      rdata1=32'hDEADBEEF, wr_count=1.
//   3. RegWrite=1, waddr=0, reg_datain=32'hFFFFFFFF -> rdata1(raddr1=0)=0, wr_count unchanged.
//   4. Same-cycle write reg 9=32'h1234 and raddr2=9 -> before edge rdata2=old value
//      (bypass off) or 32'h1234 (REGFILE_BYPASS_EN); after edge 32'h1234 in both builds.
//   5. Write regs 1..31 with value=index, then rst_n pulsed low mid-cycle ->
//      all reads 0 at once, wr_count=0 without a clock edge.
//   6. Preload wr_count near wrap (CNT_W=4 build): 16 valid writes -> wr_count returns to 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared register-file definitions used by decode, forwarding and write-back logic.
// Width defaults, the hard-wired $zero index and a small index helper.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [DEF_DATA_W-1:0] word_t;
  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

  function automatic logic is_reg_zero(input reg_idx_t idx);
    return idx == REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational register-file read port: forces $zero to 0 and, when
// BYPASS_EN is set, forwards same-cycle write data to the reader.
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter bit BYPASS_EN = 1'b0
) (
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [DATA_W-1:0] stored_i,
  input  logic              wen_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic bypass_hit;

  // A write to $zero is never forwarded, since the zero check takes priority.
  assign bypass_hit = BYPASS_EN && wen_i && (waddr_i == raddr_i);

  always_comb begin
    rdata_o = stored_i;
    if (raddr_i == '0) begin
      rdata_o = '0;
    end else if (bypass_hit) begin
      rdata_o = wdata_i;
    end
  end

endmodule

// File: rtl/reg_file.sv
// MIPS 32 x 32-bit register file: two operand read ports, one write port,
// a debug read port and a committed-write counter. Macro REGFILE_BYPASS_EN
// enables same-cycle write-to-read forwarding on rdata1/rdata2 only.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] reg_datain,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int NREGS = 1 << ADDR_W;

`ifdef REGFILE_BYPASS_EN
  localparam bit OPERAND_BYPASS = 1'b1;
`else
  localparam bit OPERAND_BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              commit;

  assign commit  = RegWrite && (waddr != '0);
  assign count_d = count_q + CNT_W'(1);

  // Entry 0 is cleared on reset and never written, so storage agrees with $zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      count_q <= '0;
    end else if (commit) begin
      regs_q[waddr] <= reg_datain;
      count_q       <= count_d;
    end
  end

  assign wr_count = count_q;

  reg_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BYPASS_EN(OPERAND_BYPASS)
  ) u_port1 (
    .raddr_i (raddr1),
    .stored_i(regs_q[raddr1]),
    .wen_i   (RegWrite),
    .waddr_i (waddr),
    .wdata_i (reg_datain),
    .rdata_o (rdata1)
  );

  reg_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BYPASS_EN(OPERAND_BYPASS)
  ) u_port2 (
    .raddr_i (raddr2),
    .stored_i(regs_q[raddr2]),
    .wen_i   (RegWrite),
    .waddr_i (waddr),
    .wdata_i (reg_datain),
    .rdata_o (rdata2)
  );

  // The board display always shows committed state, never in-flight data.
  reg_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BYPASS_EN(1'b0)
  ) u_dbg_port (
    .raddr_i (dbg_addr),
    .stored_i(regs_q[dbg_addr]),
    .wen_i   (RegWrite),
    .waddr_i (waddr),
    .wdata_i (reg_datain),
    .rdata_o (dbg_data)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; a second instance with CNT_W=4
// exercises counter wrap. Build with +define+REGFILE_BYPASS_EN for the bypass variant.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        RegWrite;
  logic [4:0]  waddr;
  logic [31:0] reg_datain;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [4:0]  dbg_addr;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] dbg_data;
  logic [31:0] wr_count;
  logic [31:0] rdata1_s;
  logic [31:0] rdata2_s;
  logic [31:0] dbg_data_s;
  logic [3:0]  wr_count_s;

  int checks;
  int failures;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  reg_file dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RegWrite  (RegWrite),
    .waddr     (waddr),
    .reg_datain(reg_datain),
    .raddr1    (raddr1),
    .rdata1    (rdata1),
    .raddr2    (raddr2),
    .rdata2    (rdata2),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .wr_count  (wr_count)
  );

  reg_file #(.CNT_W(4)) dut_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .RegWrite  (RegWrite),
    .waddr     (waddr),
    .reg_datain(reg_datain),
    .raddr1    (raddr1),
    .rdata1    (rdata1_s),
    .raddr2    (raddr2),
    .rdata2    (rdata2_s),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data_s),
    .wr_count  (wr_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One write strobe: inputs set on the falling edge, dropped 1ns after the rising edge.
  task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    RegWrite   = 1'b1;
    waddr      = addr;
    reg_datain = data;
    @(posedge clk);
    #1;
    RegWrite   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    RegWrite   = 1'b1;
    waddr      = 5'd3;
    reg_datain = 32'hA5A5A5A5;
    raddr1     = '0;
    raddr2     = '0;
    dbg_addr   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    RegWrite = 1'b0;
    rst_n    = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      raddr1   = 5'(i);
      raddr2   = 5'(31 - i);
      dbg_addr = 5'(i);
      #1;
      checks++;
      if (rdata1 !== 32'd0 || rdata2 !== 32'd0 || dbg_data !== 32'd0) begin
        failures++;
        $display("[TB] FAIL reset_read idx=%0d got r1=%h r2=%h dbg=%h want 0", i, rdata1, rdata2, dbg_data);
      end
    end
    checks++;
    if (wr_count !== 32'd0 || wr_count_s !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_count got %0d/%0d want 0", wr_count, wr_count_s);
    end
  endtask

  task automatic test_write();
    applyStimulus(5'd8, 32'hDEADBEEF);
    raddr1   = 5'd8;
    raddr2   = 5'd8;
    dbg_addr = 5'd8;
    #1;
    checks++;
    if (rdata1 !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL write_rdata1 got %h want deadbeef", rdata1);
    end
    checks++;
    if (rdata2 !== 32'hDEADBEEF || dbg_data !== 32'hDEADBEEF) begin
      failures++;
      $display("[TB] FAIL same_addr_ports got r2=%h dbg=%h want deadbeef", rdata2, dbg_data);
    end
    checks++;
    if (wr_count !== 32'd1) begin
      failures++;
      $display("[TB] FAIL write_count got %0d want 1", wr_count);
    end
  endtask

  task automatic test_zero_write();
    applyStimulus(5'd0, 32'hFFFFFFFF);
    raddr1   = 5'd0;
    raddr2   = 5'd0;
    dbg_addr = 5'd0;
    #1;
    checks++;
    if (rdata1 !== 32'd0 || rdata2 !== 32'd0 || dbg_data !== 32'd0) begin
      failures++;
      $display("[TB] FAIL zero_read got r1=%h r2=%h dbg=%h want 0", rdata1, rdata2, dbg_data);
    end
    checks++;
    if (wr_count !== 32'd1) begin
      failures++;
      $display("[TB] FAIL zero_count got %0d want 1", wr_count);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_pre;
    exp_pre = BYPASS ? 32'h00001234 : 32'h00000000;
    @(negedge clk);
    raddr1     = 5'd9;
    raddr2     = 5'd9;
    dbg_addr   = 5'd9;
    RegWrite   = 1'b1;
    waddr      = 5'd9;
    reg_datain = 32'h00001234;
    #1;
    checks++;
    if (rdata2 !== exp_pre || rdata1 !== exp_pre) begin
      failures++;
      $display("[TB] FAIL same_cycle_pre got r1=%h r2=%h want %h", rdata1, rdata2, exp_pre);
    end
    checks++;
    if (dbg_data !== 32'd0) begin
      failures++;
      $display("[TB] FAIL dbg_no_bypass got %h want 0", dbg_data);
    end
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    #1;
    checks++;
    if (rdata2 !== 32'h00001234 || dbg_data !== 32'h00001234) begin
      failures++;
      $display("[TB] FAIL same_cycle_post got r2=%h dbg=%h want 00001234", rdata2, dbg_data);
    end
    checks++;
    if (wr_count !== 32'd2) begin
      failures++;
      $display("[TB] FAIL same_cycle_count got %0d want 2", wr_count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i < 32; i++) begin
      applyStimulus(5'(i), 32'(i));
    end
    for (int i = 0; i < 32; i++) begin
      raddr1   = 5'(i);
      raddr2   = 5'(31 - i);
      dbg_addr = 5'(i);
      #1;
      checks++;
      if (rdata1 !== 32'(i) || rdata2 !== 32'(31 - i) || dbg_data !== 32'(i)) begin
        failures++;
        $display("[TB] FAIL b2b_read idx=%0d got r1=%h r2=%h dbg=%h want %h/%h", i, rdata1, rdata2, dbg_data, i, 31 - i);
      end
    end
    checks++;
    if (wr_count !== 32'd33) begin
      failures++;
      $display("[TB] FAIL b2b_count got %0d want 33", wr_count);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i += 5) begin
      raddr1   = 5'(i);
      raddr2   = 5'(i + 1);
      dbg_addr = 5'(i);
      #1;
      checks++;
      if (rdata1 !== 32'd0 || rdata2 !== 32'd0 || dbg_data !== 32'd0) begin
        failures++;
        $display("[TB] FAIL async_reset_read idx=%0d got r1=%h r2=%h dbg=%h want 0", i, rdata1, rdata2, dbg_data);
      end
    end
    checks++;
    if (wr_count !== 32'd0) begin
      failures++;
      $display("[TB] FAIL async_reset_count got %0d want 0", wr_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(5'((i % 31) + 1), 32'h100 + 32'(i));
    end
    #1;
    checks++;
    if (wr_count_s !== 4'd15) begin
      failures++;
      $display("[TB] FAIL wrap_pre got %0d want 15", wr_count_s);
    end
    applyStimulus(5'd16, 32'hCAFE0016);
    #1;
    checks++;
    if (wr_count_s !== 4'd0) begin
      failures++;
      $display("[TB] FAIL wrap_zero got %0d want 0", wr_count_s);
    end
    checks++;
    if (wr_count !== 32'd16) begin
      failures++;
      $display("[TB] FAIL wide_count got %0d want 16", wr_count);
    end
    raddr1 = 5'd16;
    #1;
    checks++;
    if (rdata1_s !== 32'hCAFE0016 || rdata1 !== 32'hCAFE0016) begin
      failures++;
      $display("[TB] FAIL wrap_data got %h/%h want cafe0016", rdata1_s, rdata1);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_write();
    test_zero_write();
    test_same_cycle();
    test_back_to_back();
    test_async_reset();
    checkOutput();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
